// File: rtl/config_write_arbiter.sv
// Session arbiter sharing the ConfigFSM write port between NUM_SRC sources.
// Optional macro CFG_ARB_ROUND_ROBIN_EN: round-robin owner selection.
module config_write_arbiter #(
  parameter int NUM_SRC        = 3,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_active,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_strobe,
  input  logic                          flag_clear,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          busy,
  output logic [DATA_WIDTH-1:0]         cfg_write_data,
  output logic                          cfg_write_strobe,
  output logic                          fsm_reset,
  output logic [NUM_SRC-1:0]            drop_flag,
  output logic [NUM_SRC-1:0]            timeout_flag
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SYNC, OWNED, RELEASE} state_t;

  state_t              state, state_n;
  logic [IW-1:0]       owner, owner_n, sel;
  logic                sel_valid;
  logic [CW-1:0]       idle_cnt, idle_cnt_n;
  logic [NUM_SRC-1:0]  lockout, lockout_n;
  logic [NUM_SRC-1:0]  eligible, owner_oh, fwd_mask;
  logic [NUM_SRC-1:0]  drop_set, tmo_set;
  logic                own_strobe, own_active, timeout_hit;

  logic [NUM_SRC-1:0]    grant_d, drop_d, tmo_d;
  logic                  busy_d, strobe_d, fsm_reset_d;
  logic [DATA_WIDTH-1:0] data_d;

  assign eligible    = src_active & ~lockout;
  assign owner_oh    = NUM_SRC'(1) << owner;
  assign own_strobe  = |(src_strobe & owner_oh);
  assign own_active  = |(src_active & owner_oh);
  assign timeout_hit = (state == OWNED) && own_active && !own_strobe &&
                       (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

`ifdef CFG_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] last;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    int idx;
    idx       = 0;
    sel       = '0;
    sel_valid = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = (int'(last) + 1 + k) % NUM_SRC;
      if (eligible[idx]) begin
        sel       = IW'(idx);
        sel_valid = 1'b1;
      end
    end
  end

  // Remember the most recent owner; reset value makes source 0 first.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)
      last <= IW'(NUM_SRC - 1);
    else if (state == IDLE && sel_valid)
      last <= sel;
  end
`else
  // Fixed priority: the lowest eligible index wins.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel       = IW'(i);
        sel_valid = 1'b1;
      end
    end
  end
`endif

  // State, owner, idle counter and lockout registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      idle_cnt <= '0;
      lockout  <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      idle_cnt <= idle_cnt_n;
      lockout  <= lockout_n;
    end
  end

  // Session sequencing: select, sync, own, release.
  always_comb begin
    state_n    = state;
    owner_n    = owner;
    idle_cnt_n = idle_cnt;
    unique case (state)
      IDLE: begin
        if (sel_valid) begin
          owner_n = sel;
          state_n = SYNC;
        end
      end
      SYNC: begin
        idle_cnt_n = '0;
        state_n    = OWNED;
      end
      OWNED: begin
        idle_cnt_n = own_strobe ? '0 : idle_cnt + CW'(1);
        if (!own_active || timeout_hit)
          state_n = RELEASE;
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values for the registered outputs and sticky bookkeeping.
  always_comb begin
    fwd_mask    = (state == OWNED) ? owner_oh : '0;
    drop_set    = src_strobe & ~fwd_mask;
    tmo_set     = timeout_hit ? owner_oh : '0;
    lockout_n   = (lockout & src_active) | tmo_set;
    busy_d      = (state_n == SYNC) || (state_n == OWNED);
    grant_d     = busy_d ? (NUM_SRC'(1) << owner_n) : '0;
    fsm_reset_d = (state_n == SYNC);
    strobe_d    = (state == OWNED) && own_strobe;
    data_d      = strobe_d ?
                  src_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH] :
                  cfg_write_data;
    drop_d      = (drop_flag & ~{NUM_SRC{flag_clear}}) | drop_set;
    tmo_d       = (timeout_flag & ~{NUM_SRC{flag_clear}}) | tmo_set;
  end

  // Output registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      grant            <= '0;
      busy             <= 1'b0;
      cfg_write_data   <= '0;
      cfg_write_strobe <= 1'b0;
      fsm_reset        <= 1'b0;
      drop_flag        <= '0;
      timeout_flag     <= '0;
    end else begin
      grant            <= grant_d;
      busy             <= busy_d;
      cfg_write_data   <= data_d;
      cfg_write_strobe <= strobe_d;
      fsm_reset        <= fsm_reset_d;
      drop_flag        <= drop_d;
      timeout_flag     <= tmo_d;
    end
  end

endmodule

// File: tb/tb_config_write_arbiter.sv
// Directed bench for config_write_arbiter with a write-word scoreboard.
// Default build (fixed priority), TIMEOUT_CYCLES=16.
module tb_config_write_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          reset;
  logic [N-1:0]  src_active;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]  src_strobe;
  logic          flag_clear;
  logic [N-1:0]  grant;
  logic          busy;
  logic [DW-1:0] cfg_write_data;
  logic          cfg_write_strobe;
  logic          fsm_reset;
  logic [N-1:0]  drop_flag;
  logic [N-1:0]  timeout_flag;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  config_write_arbiter #(
    .NUM_SRC(N),
    .TIMEOUT_CYCLES(16),
    .DATA_WIDTH(DW)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .src_active(src_active),
    .src_data(src_data),
    .src_strobe(src_strobe),
    .flag_clear(flag_clear),
    .grant(grant),
    .busy(busy),
    .cfg_write_data(cfg_write_data),
    .cfg_write_strobe(cfg_write_strobe),
    .fsm_reset(fsm_reset),
    .drop_flag(drop_flag),
    .timeout_flag(timeout_flag)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then compare any forwarded word to the scoreboard.
  task automatic tick();
    logic [31:0] w;
    @(posedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      chk("wr_strobe", 32'(cfg_write_strobe), 32'd1);
      chk("wr_data", cfg_write_data, w);
    end else if (cfg_write_strobe) begin
      chk("unexpected_strobe", 32'(cfg_write_strobe), 32'd0);
    end
  endtask

  task automatic strobe(input int src, input logic [31:0] w,
                        input bit expect_fwd);
    src_data[src*DW +: DW] = w;
    src_strobe = N'(1) << src;
    if (expect_fwd) exp_q.push_back(w);
    tick();
    src_strobe = '0;
  endtask

  task automatic chk_sess(input string tag, input logic [N-1:0] g,
                          input logic b, input logic fr);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    chk({tag, "_fsm_reset"}, 32'(fsm_reset), 32'(fr));
  endtask

  initial begin
    reset      = 1'b1;
    src_active = '0;
    src_data   = '0;
    src_strobe = '0;
    flag_clear = 1'b0;
    tick();
    tick();
    chk_sess("rst", 3'b000, 1'b0, 1'b0);
    chk("rst_strobe", 32'(cfg_write_strobe), 32'd0);
    chk("rst_data", cfg_write_data, 32'd0);
    chk("rst_drop", 32'(drop_flag), 32'd0);
    chk("rst_tmo", 32'(timeout_flag), 32'd0);
    reset = 1'b0;
    tick();

    // Basic session on source 1
    src_active = 3'b010;
    tick();
    chk_sess("basic_sync", 3'b010, 1'b1, 1'b1);
    tick();
    chk_sess("basic_own", 3'b010, 1'b1, 1'b0);
    strobe(1, 32'hA5A5_0001, 1'b1);
    strobe(1, 32'hA5A5_0002, 1'b1);
    tick();
    chk("basic_idle_strobe", 32'(cfg_write_strobe), 32'd0);
    chk("basic_hold_data", cfg_write_data, 32'hA5A5_0002);
    src_active = 3'b000;
    tick();
    chk_sess("basic_rel", 3'b000, 1'b0, 1'b0);
    tick();
    chk_sess("basic_idle", 3'b000, 1'b0, 1'b0);

    // Contention: source 0 wins, source 2 strobe is dropped
    src_active = 3'b111;
    tick();
    chk_sess("cont_sync", 3'b001, 1'b1, 1'b1);
    tick();
    strobe(2, 32'hDEAD_BEEF, 1'b0);
    chk("cont_no_fwd", 32'(cfg_write_strobe), 32'd0);
    chk("cont_drop", 32'(drop_flag), 32'b100);
    chk("cont_grant", 32'(grant), 32'b001);
    flag_clear = 1'b1;
    tick();
    flag_clear = 1'b0;
    chk("cont_clear", 32'(drop_flag), 32'd0);

    // Handover from source 0 to source 1
    src_active = 3'b110;
    tick();
    chk_sess("hand_rel", 3'b000, 1'b0, 1'b0);
    tick();
    chk_sess("hand_gap", 3'b000, 1'b0, 1'b0);
    tick();
    chk_sess("hand_sync", 3'b010, 1'b1, 1'b1);
    tick();
    strobe(1, 32'h1234_5678, 1'b1);
    src_active = 3'b000;
    tick();
    tick();
    chk_sess("hand_end", 3'b000, 1'b0, 1'b0);

    // Timeout on idle source 1
    src_active = 3'b010;
    tick();
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_still_busy", 32'(busy), 32'd1);
    chk("tmo_not_yet", 32'(timeout_flag), 32'd0);
    tick();
    chk_sess("tmo_rel", 3'b000, 1'b0, 1'b0);
    chk("tmo_flag", 32'(timeout_flag), 32'b010);
    for (int i = 0; i < 3; i++) tick();
    chk_sess("tmo_lock", 3'b000, 1'b0, 1'b0);
    src_active = 3'b000;
    tick();
    src_active = 3'b010;
    tick();
    chk_sess("tmo_regrant", 3'b010, 1'b1, 1'b1);
    chk("tmo_sticky", 32'(timeout_flag), 32'b010);

    // Reset in the middle of an owned strobe
    tick();
    src_data[1*DW +: DW] = 32'hCAFE_0001;
    src_strobe = 3'b010;
    reset = 1'b1;
    #1;
    chk_sess("mid_rst", 3'b000, 1'b0, 1'b0);
    chk("mid_rst_strobe", 32'(cfg_write_strobe), 32'd0);
    chk("mid_rst_data", cfg_write_data, 32'd0);
    chk("mid_rst_tmo", 32'(timeout_flag), 32'd0);
    src_strobe = '0;
    tick();
    reset = 1'b0;
    tick();
    chk_sess("post_rst_sync", 3'b010, 1'b1, 1'b1);
    tick();
    chk_sess("post_rst_own", 3'b010, 1'b1, 1'b0);
    src_active = 3'b000;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
